// File: rtl/lsu_zed.sv
// Memory-stage load/store unit in front of the word-only d-cache.
// Sub-word stores become read-modify-write; loads are lane-extracted and extended.
module lsu_zed #(
    parameter int MISS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_fault,
    output logic        busy,
    output logic [31:0] d_addr,
    output logic        d_rd,
    output logic        d_wr,
    output logic [31:0] d_wr_data,
    input  logic        d_miss,
    input  logic [31:0] d_rd_data,
    input  logic        d_segfault
);
    localparam int CW = $clog2(MISS_TIMEOUT + 2);
    localparam logic [CW-1:0] TMO = CW'(MISS_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE, RD, RD_WAIT, WR, WR_WAIT, RESP
    } state_t;

    state_t         state_q, state_d;
    logic           we_q, we_d;
    logic [1:0]     size_q, size_d;
    logic           sgn_q, sgn_d;
    logic [1:0]     off_q, off_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    d_addr_q, d_addr_d;
    logic [31:0]    d_wr_data_q, d_wr_data_d;
    logic [31:0]    rdata_q, rdata_d;
    logic [1:0]     fault_q, fault_d;

    logic [7:0]     b_lane;
    logic [15:0]    h_lane;
    logic [31:0]    load_val;
    logic [31:0]    merged;
    logic           misaligned;

    assign misaligned = (req_size == 2'b11)
                      | ((req_size == 2'b01) & req_addr[0])
                      | ((req_size == 2'b10) & (|req_addr[1:0]));

    // Lane views of the returned word, used for both load and merge
    always_comb begin
        b_lane   = d_rd_data[{off_q, 3'b000} +: 8];
        h_lane   = d_rd_data[{off_q[1], 4'b0000} +: 16];
        load_val = d_rd_data;
        merged   = d_rd_data;
        case (size_q)
            2'b00: begin
                load_val = {{24{sgn_q & b_lane[7]}}, b_lane};
                merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
            end
            2'b01: begin
                load_val = {{16{sgn_q & h_lane[15]}}, h_lane};
                merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        sgn_d       = sgn_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        d_addr_d    = d_addr_q;
        d_wr_data_d = d_wr_data_q;
        rdata_d     = '0;
        fault_d     = '0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    size_d   = req_size;
                    sgn_d    = req_signed;
                    off_d    = req_addr[1:0];
                    wdata_d  = req_wdata;
                    d_addr_d = {req_addr[31:2], 2'b00};
                    cnt_d    = '0;
                    if (misaligned) begin
                        state_d = RESP;
                        fault_d = 2'b01;
                    end else if (!req_we || req_size != 2'b10) begin
                        state_d = RD;
                    end else begin
                        state_d     = WR;
                        d_wr_data_d = req_wdata;
                    end
                end
            end
            RD:      state_d = RD_WAIT;
            WR:      state_d = WR_WAIT;
            RD_WAIT, WR_WAIT: begin
                if (d_segfault) begin
                    state_d = RESP;
                    fault_d = 2'b10;
                end else if (d_miss) begin
                    if (cnt_q == TMO) begin
                        state_d = RESP;
                        fault_d = 2'b11;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = (state_q == RD_WAIT) ? RD : WR;
                    end
                end else if (state_q == WR_WAIT) begin
                    state_d = RESP;
                end else if (!we_q) begin
                    state_d = RESP;
                    rdata_d = load_val;
                end else begin
                    state_d     = WR;
                    d_wr_data_d = merged;
                    cnt_d       = '0;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            sgn_q       <= 1'b0;
            off_q       <= 2'b00;
            wdata_q     <= '0;
            cnt_q       <= '0;
            d_addr_q    <= '0;
            d_wr_data_q <= '0;
            rdata_q     <= '0;
            fault_q     <= 2'b00;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            sgn_q       <= sgn_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            d_addr_q    <= d_addr_d;
            d_wr_data_q <= d_wr_data_d;
            rdata_q     <= rdata_d;
            fault_q     <= fault_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign resp_valid = (state_q == RESP);
    assign d_rd       = (state_q == RD);
    assign d_wr       = (state_q == WR);
    assign d_addr     = d_addr_q;
    assign d_wr_data  = d_wr_data_q;
    assign resp_rdata = rdata_q;
    assign resp_fault = fault_q;
endmodule

// File: tb/tb_lsu_zed.sv
// Scoreboard bench for lsu_zed: random and directed requests against a
// word-memory reference model, with a registered cache model attached.
module tb_lsu_zed;
    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready, resp_valid, busy, d_rd, d_wr;
    logic [31:0] resp_rdata, d_addr, d_wr_data;
    logic [1:0]  resp_fault;
    logic        d_miss = 1'b0;
    logic        d_segfault = 1'b0;
    logic [31:0] d_rd_data = '0;

    lsu_zed #(.MISS_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_fault(resp_fault), .busy(busy),
        .d_addr(d_addr), .d_rd(d_rd), .d_wr(d_wr),
        .d_wr_data(d_wr_data), .d_miss(d_miss),
        .d_rd_data(d_rd_data), .d_segfault(d_segfault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  fault;
        int          acc;
        int          lat;
        int          nrd;
        int          nwr;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_mem [0:1023];
    logic [31:0] cmem [0:1023];
    logic        load_init = 1'b0;
    int          miss_cfg = 0;
    int          txn_id = 0;
    int          seen_id = -1;
    int          used = 0;
    int          checks = 0;
    int          errors = 0;

    function automatic bit seg(input logic [31:0] a);
        return (a[31:16] == 16'h0002) || (a[31:8] == 24'h0);
    endfunction

    // Cache: registered flags/data, a per-request miss budget, segfault map
    always @(posedge clk) begin
        int u;
        if (load_init)
            for (int i = 0; i < 1024; i++) cmem[i] <= ref_mem[i];
        if (rst) begin
            d_miss     <= 1'b0;
            d_segfault <= 1'b0;
        end else if (d_rd || d_wr) begin
            u = (txn_id != seen_id) ? 0 : used;
            seen_id <= txn_id;
            if (seg(d_addr)) begin
                d_segfault <= 1'b1;
                d_miss     <= 1'b0;
                used       <= u;
            end else if (u < miss_cfg) begin
                d_segfault <= 1'b0;
                d_miss     <= 1'b1;
                used       <= u + 1;
            end else begin
                d_segfault <= 1'b0;
                d_miss     <= 1'b0;
                used       <= u;
                if (d_rd) d_rd_data <= cmem[d_addr[11:2]];
                if (d_wr) cmem[d_addr[11:2]] <= d_wr_data;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, req);
        end
    endtask

    function automatic void phase(inout int rem, output int s, output bit to);
        if (rem > T) begin
            s = T + 1;
            rem -= T + 1;
            to = 1'b1;
        end else begin
            s = rem + 1;
            rem = 0;
            to = 1'b0;
        end
    endfunction

    function automatic exp_t model(input logic we, input logic [1:0] sz,
                                   input logic sg, input logic [31:0] a,
                                   input logic [31:0] wd, input int m);
        exp_t e;
        int rem, s, sh, bits;
        bit to;
        logic [31:0] w, mask, nw;
        logic [9:0] idx;
        e.rdata = '0; e.fault = '0; e.acc = 0;
        e.lat = 0; e.nrd = 0; e.nwr = 0;
        idx  = a[11:2];
        w    = ref_mem[idx];
        rem  = m;
        bits = (sz == 2'd0) ? 8 : 16;
        sh   = (sz == 2'd0) ? 8 * int'(a[1:0]) : 16 * int'(a[1]);
        mask = (32'd1 << bits) - 32'd1;
        if (sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)) begin
            e.fault = 2'd1;
            e.lat = 1;
            return e;
        end
        if (seg(a)) begin
            e.fault = 2'd2;
            e.lat = 3;
            if (!we || sz != 2'd2) e.nrd = 1;
            else e.nwr = 1;
            return e;
        end
        e.lat = 1;
        if (!we || sz != 2'd2) begin
            phase(rem, s, to);
            e.nrd = s;
            e.lat += 2 * s;
            if (to) begin
                e.fault = 2'd3;
                return e;
            end
            if (!we) begin
                if (sz == 2'd2) e.rdata = w;
                else begin
                    e.rdata = (w >> sh) & mask;
                    if (sg && e.rdata[bits-1]) e.rdata = e.rdata | ~mask;
                end
                return e;
            end
            nw = (w & ~(mask << sh)) | ((wd & mask) << sh);
        end else begin
            nw = wd;
        end
        phase(rem, s, to);
        e.nwr = s;
        e.lat += 2 * s;
        if (to) begin
            e.fault = 2'd3;
            return e;
        end
        ref_mem[idx] = nw;
        return e;
    endfunction

    task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int m, input bit exp_resp);
        int n = 0;
        exp_t e;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_wait", {31'b0, req_ready}, 32'd1);
        if (!req_ready) return;
        miss_cfg   = m;
        txn_id++;
        req_we     = we;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        if (exp_resp) begin
            e = model(we, sz, sg, a, wd, m);
            e.acc = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd0);
        chk({tag, "_d_rd"}, {31'b0, d_rd}, 32'd0);
        chk({tag, "_d_wr"}, {31'b0, d_wr}, 32'd0);
        chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        chk({tag, "_resp_fault"}, {30'b0, resp_fault}, 32'd0);
        chk({tag, "_d_addr"}, d_addr, 32'd0);
        chk({tag, "_d_wr_data"}, d_wr_data, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = $urandom;
        load_init = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        load_init = 1'b0;
        reset_checks("reset");
        @(negedge clk);
        rst = 1'b0;
        fork
            begin : mon
                int nrd = 0;
                int nwr = 0;
                bit prev = 1'b0;
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        nrd = 0;
                        nwr = 0;
                        prev = 1'b0;
                    end else begin
                        if (d_rd || d_wr)
                            chk("rd_wr_exclusive", {31'b0, d_rd & d_wr}, 32'd0);
                        nrd += int'(d_rd);
                        nwr += int'(d_wr);
                        if (prev && !resp_valid) begin
                            chk("rdata_clear", resp_rdata, 32'd0);
                            chk("fault_clear", {30'b0, resp_fault}, 32'd0);
                        end
                        if (resp_valid) begin
                            if (sb.size() == 0) begin
                                chk("unexpected_resp", 32'd1, 32'd0);
                            end else begin
                                e = sb.pop_front();
                                chk("rdata", resp_rdata, e.rdata);
                                chk("fault", {30'b0, resp_fault}, {30'b0, e.fault});
                                chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                                chk("d_rd_count", 32'(nrd), 32'(e.nrd));
                                chk("d_wr_count", 32'(nwr), 32'(e.nwr));
                            end
                            nrd = 0;
                            nwr = 0;
                        end
                        prev = resp_valid;
                    end
                end
            end
            begin : stim
                logic        we, sg;
                logic [1:0]  sz;
                logic [31:0] a;
                int          r, m, n;
                issue(1, 2'd2, 0, 32'h0001_0200, 32'hDEAD_BEEF, 0, 1);
                issue(0, 2'd2, 0, 32'h0001_0200, 32'h0, 0, 1);
                issue(1, 2'd0, 0, 32'h0001_0203, 32'h0000_005A, 0, 1);
                issue(0, 2'd2, 0, 32'h0001_0200, 32'h0, 0, 1);
                issue(0, 2'd0, 1, 32'h0001_0201, 32'h0, 0, 1);
                issue(0, 2'd0, 0, 32'h0001_0201, 32'h0, 0, 1);
                issue(0, 2'd1, 1, 32'h0001_0202, 32'h0, 0, 1);
                issue(0, 2'd1, 0, 32'h0001_0201, 32'h0, 0, 1);
                issue(0, 2'd3, 0, 32'h0001_0200, 32'h0, 0, 1);
                issue(0, 2'd2, 0, 32'h0002_0000, 32'h0, 0, 1);
                issue(1, 2'd0, 0, 32'h0000_0004, 32'h0000_0011, 0, 1);
                issue(1, 2'd2, 0, 32'h0002_0010, 32'h1234_5678, 0, 1);
                issue(0, 2'd2, 0, 32'h0001_0200, 32'h0, 2, 1);
                issue(0, 2'd2, 0, 32'h0001_0200, 32'h0, 1000, 1);
                issue(1, 2'd1, 0, 32'h0001_0302, 32'h0000_CAFE, 1000, 1);
                issue(1, 2'd2, 0, 32'h0001_0304, 32'h0BAD_F00D, T, 1);
                // Abort a byte-store RMW in its read-wait cycle
                issue(1, 2'd0, 0, 32'h0001_0201, 32'h0000_0077, 0, 0);
                @(negedge clk);
                @(negedge clk);
                rst = 1'b1;
                @(posedge clk);
                #1;
                reset_checks("midrst");
                @(negedge clk);
                rst = 1'b0;
                @(posedge clk);
                #1;
                chk("ready_after_rst", {31'b0, req_ready}, 32'd1);
                issue(0, 2'd2, 0, 32'h0001_0200, 32'h0, 0, 1);
                for (int i = 0; i < 150; i++) begin
                    we = 1'($urandom_range(0, 1));
                    sg = 1'($urandom_range(0, 1));
                    r  = $urandom_range(0, 9);
                    sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
                    a  = {16'h0001, 4'h0, 12'($urandom)};
                    if ($urandom_range(0, 9) == 0) a[31:16] = 16'h0002;
                    if ($urandom_range(0, 3) != 0) begin
                        if (sz == 2'd1) a[0] = 1'b0;
                        if (sz == 2'd2) a[1:0] = 2'b00;
                    end
                    r = $urandom_range(0, 9);
                    m = (r < 6) ? 0 : (r < 9) ? $urandom_range(1, 3)
                                              : T + 1 + $urandom_range(0, 2);
                    issue(we, sz, sg, a, $urandom, m, 1);
                end
                n = 0;
                while (sb.size() != 0 && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                chk("drain", 32'(sb.size()), 32'd0);
            end
        join_any
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, errors);
        $finish;
    end
endmodule
